uart_tx: RTL and testbench

//   8N1 UART transmitter: serialises one byte per request onto a single TX line.

---
 rtl/uart_tx.sv | 121 ++++++++++++
 tb/tb_uart_tx.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter.
// A frame is one start bit (0), eight data bits sent LSB first, then one stop bit (1).
// A free-running baud counter sets the bit timing. It restarts at every bit boundary,
// so each bit lasts exactly CLKS_PER_BIT clocks and timing does not drift across a frame.
module uart_tx #(
    parameter int CLK_FREQ     = 12000000,
    parameter int BAUD_RATE    = 9600,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data_in,
    output logic       tx,
    output logic       busy
);

    localparam int              CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state, next_state;
    logic [CNT_W-1:0] baud_cnt, baud_cnt_next;
    logic [2:0]       bit_idx, bit_idx_next;
    logic [7:0]       shift_reg, shift_reg_next;
    logic             tx_next, busy_next;
    logic             baud_done;

    // A bit period ends on the last count of the baud counter.
    assign baud_done = (baud_cnt == CNT_LAST);

    // State and datapath registers. tx and busy are registered, so the pin never glitches.
    // NOTE: use a synchronous reset because it is sampled on the clock edge, and reset every
    // register (including the shift register) so that an aborted frame leaves nothing behind.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: assign sequential state with non-blocking (<=) so that every register updates from pre-edge values.
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            tx        <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= next_state;
            baud_cnt  <= baud_cnt_next;
            bit_idx   <= bit_idx_next;
            shift_reg <= shift_reg_next;
            tx        <= tx_next;
            busy      <= busy_next;
        end
    end

    // Next-state logic: move through the frame phases on baud boundaries.
    always_comb begin
        // NOTE: give every signal a default value first, so that no path through the case infers a latch.
        next_state = state;
        unique case (state)
            IDLE:    if (start)                        next_state = START;
            START:   if (baud_done)                    next_state = DATA;
            DATA:    if (baud_done && bit_idx == 3'd7) next_state = STOP;
            STOP:    if (baud_done)                    next_state = IDLE;
            default:                                   next_state = IDLE;
        endcase
    end

    // Output and datapath logic: compute the values that the registers load at the next edge.
    always_comb begin
        baud_cnt_next  = baud_done ? '0 : baud_cnt + CNT_W'(1);
        bit_idx_next   = bit_idx;
        shift_reg_next = shift_reg;
        tx_next        = tx;
        busy_next      = busy;
        unique case (state)
            IDLE: begin
                baud_cnt_next = '0;
                bit_idx_next  = '0;
                tx_next       = 1'b1;
                busy_next     = 1'b0;
                if (start) begin
                    shift_reg_next = data_in;
                    tx_next        = 1'b0;
                    busy_next      = 1'b1;
                end
            end
            START: begin
                busy_next = 1'b1;
                tx_next   = baud_done ? shift_reg[0] : 1'b0;
            end
            DATA: begin
                busy_next = 1'b1;
                if (baud_done) begin
                    if (bit_idx == 3'd7) begin
                        bit_idx_next = '0;
                        tx_next      = 1'b1;
                    end else begin
                        // Shift right so that the next data bit always sits in bit 0.
                        bit_idx_next   = bit_idx + 3'd1;
                        shift_reg_next = {1'b0, shift_reg[7:1]};
                        tx_next        = shift_reg[1];
                    end
                end
            end
            STOP: begin
                tx_next   = 1'b1;
                busy_next = !baud_done;
            end
            default: begin
                tx_next   = 1'b1;
                busy_next = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx.
// The bench uses a short bit period so that many frames fit in a short run.
// Expected line levels come from the 8N1 frame definition: bit k of {stop, data, start}
// holds for CPB clocks, starting at the edge that accepts the request.
module tb_uart_tx;

    localparam int CPB = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       tx;
    logic       busy;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    uart_tx #(
        .CLK_FREQ (CPB * 10000),
        .BAUD_RATE(10000)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .data_in(data_in),
        .tx     (tx),
        .busy   (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Send one byte and check the whole frame cycle by cycle, at points away from the clock edge.
    // Arguments:
    //   hold    = number of accepting-or-later edges during which start stays high
    //   disturb = change data_in and pulse start in the middle of the frame
    //   b2b     = keep start high through the end of the frame
    task automatic run_frame(input string name, input logic [7:0] b, input int hold,
                             input bit disturb, input bit b2b);
        logic [9:0] bits;
        int k, off, exp_state, wait_cnt;
        bits = {1'b1, b, 1'b0};
        @(negedge clock);
        data_in = b;
        start   = 1'b1;
        @(posedge clock);
        for (int c = 0; c <= 10 * CPB + 2; c++) begin
            @(negedge clock);
            if (!b2b && c == hold - 1) start = 1'b0;
            if (disturb && c == 4 * CPB) begin
                data_in = ~b;
                start   = 1'b1;
            end
            if (disturb && c == 4 * CPB + 1) start = 1'b0;
            if (c < 10 * CPB) begin
                k   = c / CPB;
                off = c % CPB;
                if (off == 0 || off == CPB / 2 || off == CPB - 1)
                    check($sformatf("%s_tx_bit%0d_off%0d", name, k, off), 32'(tx), 32'(bits[k]));
                if (off == CPB / 2) begin
                    exp_state = (k == 0) ? 1 : (k == 9) ? 3 : 2;
                    check($sformatf("%s_state_bit%0d", name, k), 32'(dut.state), 32'(exp_state));
                    check($sformatf("%s_busy_bit%0d", name, k), 32'(busy), 32'd1);
                end
            end else if (c == 10 * CPB) begin
                check({name, "_end_busy"}, 32'(busy), 32'd0);
                check({name, "_end_tx"}, 32'(tx), 32'd1);
                check({name, "_end_state"}, 32'(dut.state), 32'd0);
            end else if (b2b && c == 10 * CPB + 1) begin
                check({name, "_b2b_busy"}, 32'(busy), 32'd1);
                check({name, "_b2b_tx"}, 32'(tx), 32'd0);
                start = 1'b0;
                break;
            end else if (c == 10 * CPB + 2) begin
                check({name, "_single_frame"}, 32'(busy), 32'd0);
            end
        end
        if (b2b) begin
            wait_cnt = 0;
            while (busy && wait_cnt < 12 * CPB) begin
                @(negedge clock);
                wait_cnt++;
            end
            check({name, "_b2b_done"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        logic [7:0] rb;
        int         rh;

        // Hold reset for 10 clocks. After release the line must stay idle while start is low.
        repeat (10) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            repeat (5) @(negedge clock);
            check($sformatf("idle_tx_%0d", i), 32'(tx), 32'd1);
            check($sformatf("idle_busy_%0d", i), 32'(busy), 32'd0);
            check($sformatf("idle_state_%0d", i), 32'(dut.state), 32'd0);
        end

        // Directed bytes, each sent after the line has been idle for 100 clocks.
        run_frame("b55", 8'h55, 2, 1'b0, 1'b0);
        repeat (100) @(negedge clock);
        run_frame("bAA", 8'hAA, 1, 1'b0, 1'b0);
        repeat (100) @(negedge clock);
        run_frame("bFF", 8'hFF, 5, 1'b0, 1'b0);
        repeat (100) @(negedge clock);
        run_frame("b00", 8'h00, 1, 1'b0, 1'b0);
        repeat (100) @(negedge clock);
        run_frame("b41", 8'h41, 3, 1'b0, 1'b0);

        // A mid-frame change of data_in, plus a start pulse, must not alter or queue anything.
        repeat (7) @(negedge clock);
        run_frame("disturb", 8'hC3, 2, 1'b1, 1'b0);

        // If start is still high when the frame ends, the next frame starts at once.
        repeat (3) @(negedge clock);
        run_frame("b2b", 8'h5A, 0, 1'b0, 1'b1);

        // A reset during the data phase aborts the frame at the next edge.
        repeat (4) @(negedge clock);
        data_in = 8'h3C;
        start   = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (3 * CPB + 3) @(negedge clock);
        check("abort_pre_state", 32'(dut.state), 32'd2);
        reset = 1'b1;
        @(negedge clock);
        check("abort_tx", 32'(tx), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_state", 32'(dut.state), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("abort_quiet", 32'(busy), 32'd0);
        run_frame("post_abort", 8'h96, 1, 1'b0, 1'b0);

        // Random bytes, with random start-pulse lengths and random idle gaps.
        for (int i = 0; i < 6; i++) begin
            rb = 8'($urandom);
            rh = $urandom_range(1, 3 * CPB);
            repeat ($urandom_range(0, 5)) @(negedge clock);
            run_frame($sformatf("rnd%0d", i), rb, rh, 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
